// File: rtl/timer_sched_wb_pkg.sv
// -----------------------------------------------------------------------------
// timer_sched_wb_pkg
//   Shared definitions for the Wishbone alarm scheduler:
//   - register word addresses and CTRL bit positions
//   - the decoded core-register write strobes (struct)
//   - the wrap-safe deadline comparison used by the slot scanner
// -----------------------------------------------------------------------------
package timer_sched_wb_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  // Register word addresses
  localparam logic [ADDR_W-1:0] ADDR_CTRL     = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_NOW      = 4'h1;
  localparam logic [ADDR_W-1:0] ADDR_PEND     = 4'h2;
  localparam logic [ADDR_W-1:0] ADDR_ARMED    = 4'h3;
  localparam logic [ADDR_W-1:0] ADDR_DL_BASE  = 4'h4;  // DEADLINE[i] at 0x4+i
  localparam logic [ADDR_W-1:0] ADDR_PER_BASE = 4'h8;  // PERIOD[i]   at 0x8+i

  // CTRL bit positions
  localparam int CTRL_RUN    = 0;
  localparam int CTRL_IRQ_EN = 1;

  // One-hot strobes for writes to the core (non-slot) registers
  typedef struct packed {
    logic ctrl;
    logic now;
    logic pend;
    logic armed;
  } core_wr_t;

  // True when 'now' has reached or passed 'deadline', treating the difference
  // as a signed 32-bit quantity so the compare survives NOW wrapping through
  // 2^32 (valid while the two are within 2^31 ticks of each other).
  function automatic logic deadline_reached(input logic [DATA_W-1:0] now,
                                            input logic [DATA_W-1:0] deadline);
    logic [DATA_W-1:0] diff;
    diff = now - deadline;
    return ~diff[DATA_W-1];
  endfunction

endpackage

// File: rtl/timer_sched_wb_if.sv
// -----------------------------------------------------------------------------
// timer_sched_wb_if
//   Minimal Wishbone-style peripheral bus bundle for the alarm scheduler.
//   Signals:
//     wb_addr  [3:0]  word address            (master -> slave)
//     wb_wdata [31:0] write data              (master -> slave)
//     wb_we           write enable            (master -> slave)
//     wb_cyc          bus cycle               (master -> slave)
//     wb_rdata [31:0] read data, 0 unless ack (slave -> master)
//     wb_ack          registered acknowledge  (slave -> master)
// -----------------------------------------------------------------------------
interface timer_sched_wb_if;
  import timer_sched_wb_pkg::*;

  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_wdata;
  logic              wb_we;
  logic              wb_cyc;
  logic [DATA_W-1:0] wb_rdata;
  logic              wb_ack;

  modport master (
    output wb_addr, wb_wdata, wb_we, wb_cyc,
    input  wb_rdata, wb_ack
  );

  modport slave (
    input  wb_addr, wb_wdata, wb_we, wb_cyc,
    output wb_rdata, wb_ack
  );

endinterface

// File: rtl/timer_sched_presc.sv
// -----------------------------------------------------------------------------
// timer_sched_presc
//   Clock prescaler producing one tick request every DIV clocks while run=1.
//   Ports:
//     clk      in   system clock
//     rst_n    in   asynchronous active-low reset (counter reloads to DIV-1)
//     run      in   1 = count down, 0 = hold at DIV-1
//     restart  in   reload to DIV-1 this clock (NOW is being written)
//     tick_evt out  combinational: NOW should advance on this clock edge
// -----------------------------------------------------------------------------
module timer_sched_presc #(
  parameter int DIV = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic tick_evt
);

  localparam int            CW     = $clog2(DIV);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;

  // A restart suppresses the tick so a freshly written NOW is not bumped.
  assign tick_evt = run & ~restart & (cnt_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= RELOAD;
    end else if (restart || !run || (cnt_reg == '0)) begin
      cnt_reg <= RELOAD;
    end else begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

endmodule

// File: rtl/timer_sched_wb.sv
// -----------------------------------------------------------------------------
// timer_sched_wb
//   Wishbone alarm scheduler: one free-running 32-bit tick counter (NOW)
//   shared by NSLOT alarm slots. A round-robin scanner checks one slot per
//   clock; an expired slot sets its pending bit and is either disarmed
//   (PERIOD=0) or advanced by PERIOD and left armed. Any pending bit raises
//   irq when irq_en is set.
//   Ports:
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset
//     bus    slave modport of timer_sched_wb_if (addr/wdata/we/cyc/rdata/ack)
//     irq    out  registered level interrupt: irq_en & |pend
//     tick   out  1-clk pulse, high in the cycle NOW has just incremented
//   Register map (word addresses):
//     0x0 CTRL [0] run, [1] irq_en     0x1 NOW (W reloads prescaler)
//     0x2 PEND (W1C)                   0x3 ARMED (W1 disarms)
//     0x4+i DEADLINE[i] (W arms)       0x8+i PERIOD[i] (0 = one-shot)
// -----------------------------------------------------------------------------
module timer_sched_wb
  import timer_sched_wb_pkg::*;
#(
  parameter int DIV   = 24,
  parameter int NSLOT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  timer_sched_wb_if.slave        bus,
  output logic                   irq,
  output logic                   tick
);

  localparam int SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              ack_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              run_reg;
  logic              irq_en_reg;
  logic              irq_reg;
  logic              tick_reg;
  logic [DATA_W-1:0] now_reg;
  logic [SLOT_W-1:0] idx_reg;
  logic [NSLOT-1:0]  pend_reg;
  logic [NSLOT-1:0]  armed_reg;
  logic [DATA_W-1:0] deadline_reg [NSLOT];
  logic [DATA_W-1:0] period_reg   [NSLOT];

  // Next-state values computed per slot
  logic [NSLOT-1:0]  pend_next;
  logic [NSLOT-1:0]  armed_next;
  logic [DATA_W-1:0] deadline_next [NSLOT];
  logic [DATA_W-1:0] period_next   [NSLOT];

  // ---------------------------------------------------------------------------
  // Bus write decode. A write takes effect on the edge where ack is high, so
  // a reset that clears ack mid-cycle drops the write.
  // ---------------------------------------------------------------------------
  logic              wr_commit;
  core_wr_t          core_wr;
  logic [NSLOT-1:0]  dl_wr;
  logic [NSLOT-1:0]  per_wr;
  logic              tick_evt;

  assign wr_commit = bus.wb_cyc & ack_reg & bus.wb_we;

  always_comb begin
    core_wr = '0;
    if (wr_commit) begin
      case (bus.wb_addr)
        ADDR_CTRL:  core_wr.ctrl  = 1'b1;
        ADDR_NOW:   core_wr.now   = 1'b1;
        ADDR_PEND:  core_wr.pend  = 1'b1;
        ADDR_ARMED: core_wr.armed = 1'b1;
        default:    core_wr       = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler: a NOW write restarts it so the new value gets a full tick.
  // ---------------------------------------------------------------------------
  timer_sched_presc #(
    .DIV (DIV)
  ) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run_reg),
    .restart  (core_wr.now),
    .tick_evt (tick_evt)
  );

  // ---------------------------------------------------------------------------
  // Scanner compare for the slot currently under idx_reg
  // ---------------------------------------------------------------------------
  logic scan_hit;

  assign scan_hit = armed_reg[idx_reg] &
                    deadline_reached(now_reg, deadline_reg[idx_reg]);

  // ---------------------------------------------------------------------------
  // Per-slot update rules
  //   pend  : scanner set beats a same-edge W1C
  //   armed : DEADLINE write arms; W1 to ARMED beats a periodic re-arm;
  //           a one-shot expiry disarms
  //   DEADLINE write on the expiry edge: bus wins and the expiry is
  //   discarded entirely (pend untouched, deadline = written value)
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      logic hit_here;
      logic one_shot;
      logic clr_pend;
      logic clr_armed;

      assign dl_wr[gi]  = wr_commit & (bus.wb_addr == ADDR_DL_BASE  + 4'(gi));
      assign per_wr[gi] = wr_commit & (bus.wb_addr == ADDR_PER_BASE + 4'(gi));

      assign one_shot  = (period_reg[gi] == '0);
      assign hit_here  = scan_hit & (idx_reg == SLOT_W'(gi)) & ~dl_wr[gi];
      assign clr_pend  = core_wr.pend  & bus.wb_wdata[gi];
      assign clr_armed = core_wr.armed & bus.wb_wdata[gi];

      assign pend_next[gi]  = hit_here | (pend_reg[gi] & ~clr_pend);
      assign armed_next[gi] = dl_wr[gi] |
                              (armed_reg[gi] & ~clr_armed & ~(hit_here & one_shot));

      assign deadline_next[gi] = dl_wr[gi]              ? bus.wb_wdata :
                                 (hit_here & ~one_shot) ? deadline_reg[gi] + period_reg[gi] :
                                                          deadline_reg[gi];
      assign period_next[gi]   = per_wr[gi] ? bus.wb_wdata : period_reg[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read mux (sampled into rdata_reg on the edge that raises ack)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (bus.wb_addr)
      ADDR_CTRL: begin
        rd_val[CTRL_RUN]    = run_reg;
        rd_val[CTRL_IRQ_EN] = irq_en_reg;
      end
      ADDR_NOW:   rd_val = now_reg;
      ADDR_PEND:  rd_val[NSLOT-1:0] = pend_reg;
      ADDR_ARMED: rd_val[NSLOT-1:0] = armed_reg;
      default: begin
        for (int i = 0; i < NSLOT; i++) begin
          if (bus.wb_addr == ADDR_DL_BASE + 4'(i)) begin
            rd_val = deadline_reg[i];
          end
          if (bus.wb_addr == ADDR_PER_BASE + 4'(i)) begin
            rd_val = period_reg[i];
          end
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_reg    <= 1'b0;
      rdata_reg  <= '0;
      run_reg    <= 1'b0;
      irq_en_reg <= 1'b0;
      irq_reg    <= 1'b0;
      tick_reg   <= 1'b0;
      now_reg    <= '0;
      idx_reg    <= '0;
      pend_reg   <= '0;
      armed_reg  <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        deadline_reg[i] <= '0;
        period_reg[i]   <= '0;
      end
    end else begin
      // Two-cycle handshake: ack toggles high for one clock per access
      ack_reg   <= bus.wb_cyc & ~ack_reg;
      rdata_reg <= (bus.wb_cyc & ~ack_reg) ? rd_val : '0;

      if (core_wr.ctrl) begin
        run_reg    <= bus.wb_wdata[CTRL_RUN];
        irq_en_reg <= bus.wb_wdata[CTRL_IRQ_EN];
      end

      // tick_evt is already masked by a NOW write, so the written value wins
      if (core_wr.now) begin
        now_reg <= bus.wb_wdata;
      end else if (tick_evt) begin
        now_reg <= now_reg + 1'b1;
      end
      tick_reg <= tick_evt;

      // Scanner runs regardless of run so past deadlines still fire
      idx_reg <= (idx_reg == SLOT_W'(NSLOT - 1)) ? '0 : idx_reg + 1'b1;

      pend_reg  <= pend_next;
      armed_reg <= armed_next;
      for (int i = 0; i < NSLOT; i++) begin
        deadline_reg[i] <= deadline_next[i];
        period_reg[i]   <= period_next[i];
      end

      irq_reg <= irq_en_reg & (|pend_reg);
    end
  end

  assign bus.wb_ack   = ack_reg;
  assign bus.wb_rdata = rdata_reg;
  assign irq          = irq_reg;
  assign tick         = tick_reg;

endmodule
